// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: state codes,
// opcode and ALU operation constants, and the decoded instruction class.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ADDI, C_ANDI, C_ORI, C_NOP, C_HALT, C_ILL
  } iclass_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes, shared with the ALU
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;

  // ALU operation used in T4: immediate logic ops pick their own, all else adds
  function automatic logic [3:0] alu_code(input iclass_t c);
    case (c)
      C_ANDI:  return ALU_AND;
      C_ORI:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts cycles spent in a memory-wait state; timeout is high in the
// LIMIT-th cycle of the wait. LIMIT=0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic timeout
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // clear has priority so a fresh state always starts counting from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // cycle counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // count only advances in wait states, so it reaches LIMIT-1 nowhere else
  assign timeout = (LIMIT > 0) && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the datapath: fetch plus ld/ldi/st/addi/andi/
// ori/nop/halt execute sequences, memory-ready stalls with optional
// timeout, and a retired-instruction counter.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                z_in,
  output logic                z_low_out,
  output logic                pc_in,
  output logic                read,
  output logic                write,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                c_out,
  output logic                gra,
  output logic                grb,
  output logic                r_in,
  output logic                r_out,
  output logic                ba_out,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          t_state,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  state_t              state_q, state_d;
  logic                first_q, first_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                mem_wait, retire, timeout;
  logic [3:0]          alu_sel;
  logic [OPCODE_W-1:0] opc;
  iclass_t             cls;
  logic                unused_ir;

  assign opc       = ir[31 -: OPCODE_W];
  assign unused_ir = ^ir[31-OPCODE_W:0];

  // opcode decode into instruction class; anything unlisted is illegal
  always_comb begin
    cls = C_ILL;
    if      (opc == OPCODE_W'(OP_LD))   cls = C_LD;
    else if (opc == OPCODE_W'(OP_LDI))  cls = C_LDI;
    else if (opc == OPCODE_W'(OP_ST))   cls = C_ST;
    else if (opc == OPCODE_W'(OP_ADDI)) cls = C_ADDI;
    else if (opc == OPCODE_W'(OP_ANDI)) cls = C_ANDI;
    else if (opc == OPCODE_W'(OP_ORI))  cls = C_ORI;
    else if (opc == OPCODE_W'(OP_NOP))  cls = C_NOP;
    else if (opc == OPCODE_W'(OP_HALT)) cls = C_HALT;
  end

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mem_wait),
    .clr     (first_d),
    .timeout (timeout)
  );

  // next state and Moore control decode from state plus opcode class
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    retire     = 1'b0;
    mem_wait   = 1'b0;
    alu_sel    = ALU_AND;
    pc_out     = 1'b0;  mar_in  = 1'b0;  inc_pc = 1'b0;  z_in  = 1'b0;
    z_low_out  = 1'b0;  pc_in   = 1'b0;  read   = 1'b0;  write = 1'b0;
    mdr_in     = 1'b0;  mdr_out = 1'b0;  ir_in  = 1'b0;  y_in  = 1'b0;
    c_out      = 1'b0;  gra     = 1'b0;  grb    = 1'b0;  r_in  = 1'b0;
    r_out      = 1'b0;  ba_out  = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        alu_sel = ALU_ADD;
        state_d = S_T1;
      end
      S_T1: begin
        // pc_in only on entry so a stalled fetch doesn't reload PC repeatedly
        z_low_out = 1'b1; pc_in = first_q; read = 1'b1; mdr_in = 1'b1;
        mem_wait  = 1'b1;
        if (mem_ready)    state_d = S_T2;
        else if (timeout) begin state_d = S_HALT; fault_d = 1'b1; end
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; state_d = S_T4;
          end
          C_ADDI, C_ANDI, C_ORI: begin
            grb = 1'b1; r_out = 1'b1; y_in = 1'b1; state_d = S_T4;
          end
          C_HALT:  state_d = S_HALT;
          C_NOP:   retire = 1'b1;
          default: begin illegal_op = 1'b1; retire = 1'b1; end
        endcase
      end
      S_T4: begin
        c_out = 1'b1; z_in = 1'b1; alu_sel = alu_code(cls);
        state_d = S_T5;
      end
      S_T5: begin
        z_low_out = 1'b1;
        if (cls == C_LD || cls == C_ST) begin
          mar_in = 1'b1; state_d = S_T6;
        end else begin
          gra = 1'b1; r_in = 1'b1; retire = 1'b1;
        end
      end
      S_T6: begin
        if (cls == C_ST) begin
          gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; state_d = S_T7;
        end else begin
          read = 1'b1; mdr_in = 1'b1; mem_wait = 1'b1;
          if (mem_ready)    state_d = S_T7;
          else if (timeout) begin state_d = S_HALT; fault_d = 1'b1; end
        end
      end
      S_T7: begin
        if (cls == C_ST) begin
          write = 1'b1; mem_wait = 1'b1;
          if (mem_ready)    retire = 1'b1;
          else if (timeout) begin state_d = S_HALT; fault_d = 1'b1; end
        end else begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; retire = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // run is only looked at on the instruction boundary
    if (retire) state_d = run ? S_T0 : S_IDLE;
  end

  // state-entry flag and retired counter next values
  always_comb begin
    first_d   = (state_d != state_q);
    retired_d = retired_q + CNT_W'(retire);
  end

  // sequencer registers; reset returns everything to IDLE with outputs low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      first_q   <= 1'b1;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign alu_op    = ALU_OP_W'(alu_sel);
  assign t_state   = state_q;
  assign mem_fault = fault_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected-output table driven through
// a scoreboard queue, plus hand-written reset and memory-timeout sequences.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam logic [17:0] PCO  = 18'h20000, MARI = 18'h10000, INCPC = 18'h08000;
  localparam logic [17:0] ZI   = 18'h04000, ZLO  = 18'h02000, PCI   = 18'h01000;
  localparam logic [17:0] RD   = 18'h00800, WR   = 18'h00400, MDRI  = 18'h00200;
  localparam logic [17:0] MDRO = 18'h00100, IRI  = 18'h00080, YI    = 18'h00040;
  localparam logic [17:0] CO   = 18'h00020, GRA  = 18'h00010, GRB   = 18'h00008;
  localparam logic [17:0] RI   = 18'h00004, RO   = 18'h00002, BAO   = 18'h00001;
  localparam logic [17:0] NONE = 18'h00000;

  localparam logic [31:0] I_LDI  = 32'h08800085;
  localparam logic [31:0] I_LD   = 32'h00800010;
  localparam logic [31:0] I_ST   = 32'h10800010;
  localparam logic [31:0] I_ADDI = 32'h60800001;
  localparam logic [31:0] I_ANDI = 32'h68800003;
  localparam logic [31:0] I_ORI  = 32'h70800003;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_ILL  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    int          id;
    logic [31:0] ir;
    logic        mr;
    logic        run;
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [3:0]  alu;
    logic        ill;
    logic        hlt;
    logic [15:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n, run, mem_ready;
  logic reset_n2, run2, mr2;
  logic [31:0] ir;

  logic [17:0] c1, c2;
  logic [3:0]  alu1, alu2, st1, st2;
  logic        ill1, ill2, hlt1, hlt2, flt1, flt2;
  logic [15:0] ret1, ret2;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t chk_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   seg1, seg2;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(c1[17]), .mar_in(c1[16]), .inc_pc(c1[15]), .z_in(c1[14]),
    .z_low_out(c1[13]), .pc_in(c1[12]), .read(c1[11]), .write(c1[10]),
    .mdr_in(c1[9]), .mdr_out(c1[8]), .ir_in(c1[7]), .y_in(c1[6]),
    .c_out(c1[5]), .gra(c1[4]), .grb(c1[3]), .r_in(c1[2]), .r_out(c1[1]),
    .ba_out(c1[0]), .alu_op(alu1), .t_state(st1), .illegal_op(ill1),
    .mem_fault(flt1), .halted(hlt1), .retired(ret1)
  );

  control_sequencer #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .reset_n(reset_n2), .run(run2), .mem_ready(mr2), .ir(ir),
    .pc_out(c2[17]), .mar_in(c2[16]), .inc_pc(c2[15]), .z_in(c2[14]),
    .z_low_out(c2[13]), .pc_in(c2[12]), .read(c2[11]), .write(c2[10]),
    .mdr_in(c2[9]), .mdr_out(c2[8]), .ir_in(c2[7]), .y_in(c2[6]),
    .c_out(c2[5]), .gra(c2[4]), .grb(c2[3]), .r_in(c2[2]), .r_out(c2[1]),
    .ba_out(c2[0]), .alu_op(alu2), .t_state(st2), .illegal_op(ill2),
    .mem_fault(flt2), .halted(hlt2), .retired(ret2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] i, input int mr, input int rn,
                              input state_t st, input logic [17:0] ctrl,
                              input int alu, input int ill, input int hlt, input int ret);
    vec_t v;
    v.id   = tbl.size();
    v.ir   = i;
    v.mr   = (mr != 0);
    v.run  = (rn != 0);
    v.st   = st;
    v.ctrl = ctrl;
    v.alu  = 4'(alu);
    v.ill  = (ill != 0);
    v.hlt  = (hlt != 0);
    v.ret  = 16'(ret);
    tbl.push_back(v);
  endfunction

  // fetch rows T0..T2 with memory ready
  function automatic void fetch(input logic [31:0] i, input int rn, input int ret);
    add(i, 1, rn, S_T0, PCO | MARI | INCPC | ZI, 2, 0, 0, ret);
    add(i, 1, rn, S_T1, ZLO | PCI | RD | MDRI,   0, 0, 0, ret);
    add(i, 1, rn, S_T2, MDRO | IRI,              0, 0, 0, ret);
  endfunction

  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    ir        = v.ir;
    mem_ready = v.mr;
    run       = v.run;
    exp_q.push_back(v);
  endtask

  task automatic drive_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) drive(tbl[k]);
    @(negedge clk); #2;
  endtask

  task automatic check_reset(input string name);
    check({name, "_outs"},  64'({c1, alu1, ill1, hlt1, flt1, ret1}), 64'd0);
    check({name, "_state"}, 64'(st1), 64'(S_IDLE));
  endtask

  // scoreboard: pop one expected record per cycle, compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      chk_e = exp_q.pop_front();
      check($sformatf("row%0d_state", chk_e.id), 64'(st1), 64'(chk_e.st));
      check($sformatf("row%0d_outs", chk_e.id),
            64'({c1, alu1, ill1, hlt1, flt1, ret1}),
            64'({chk_e.ctrl, chk_e.alu, chk_e.ill, chk_e.hlt, 1'b0, chk_e.ret}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ldi with memory always ready
    fetch(I_LDI, 1, 0);
    add(I_LDI, 1, 1, S_T3, GRB | BAO | YI, 0, 0, 0, 0);
    add(I_LDI, 1, 1, S_T4, CO | ZI,        2, 0, 0, 0);
    add(I_LDI, 1, 1, S_T5, ZLO | GRA | RI, 0, 0, 0, 0);
    // ld, three stall cycles in T1 and in T6
    add(I_LD, 1, 1, S_T0, PCO | MARI | INCPC | ZI, 2, 0, 0, 1);
    add(I_LD, 0, 1, S_T1, ZLO | PCI | RD | MDRI,   0, 0, 0, 1);
    add(I_LD, 0, 1, S_T1, ZLO | RD | MDRI,         0, 0, 0, 1);
    add(I_LD, 0, 1, S_T1, ZLO | RD | MDRI,         0, 0, 0, 1);
    add(I_LD, 1, 1, S_T1, ZLO | RD | MDRI,         0, 0, 0, 1);
    add(I_LD, 1, 1, S_T2, MDRO | IRI,              0, 0, 0, 1);
    add(I_LD, 1, 1, S_T3, GRB | BAO | YI,          0, 0, 0, 1);
    add(I_LD, 1, 1, S_T4, CO | ZI,                 2, 0, 0, 1);
    add(I_LD, 1, 1, S_T5, ZLO | MARI,              0, 0, 0, 1);
    add(I_LD, 0, 1, S_T6, RD | MDRI,               0, 0, 0, 1);
    add(I_LD, 0, 1, S_T6, RD | MDRI,               0, 0, 0, 1);
    add(I_LD, 0, 1, S_T6, RD | MDRI,               0, 0, 0, 1);
    add(I_LD, 1, 1, S_T6, RD | MDRI,               0, 0, 0, 1);
    add(I_LD, 1, 1, S_T7, MDRO | GRA | RI,         0, 0, 0, 1);
    // st, one stall in T7
    fetch(I_ST, 1, 2);
    add(I_ST, 1, 1, S_T3, GRB | BAO | YI,  0, 0, 0, 2);
    add(I_ST, 1, 1, S_T4, CO | ZI,         2, 0, 0, 2);
    add(I_ST, 1, 1, S_T5, ZLO | MARI,      0, 0, 0, 2);
    add(I_ST, 1, 1, S_T6, GRA | RO | MDRI, 0, 0, 0, 2);
    add(I_ST, 0, 1, S_T7, WR,              0, 0, 0, 2);
    add(I_ST, 1, 1, S_T7, WR,              0, 0, 0, 2);
    // andi and ori
    fetch(I_ANDI, 1, 3);
    add(I_ANDI, 1, 1, S_T3, GRB | RO | YI,  0, 0, 0, 3);
    add(I_ANDI, 1, 1, S_T4, CO | ZI,        0, 0, 0, 3);
    add(I_ANDI, 1, 1, S_T5, ZLO | GRA | RI, 0, 0, 0, 3);
    fetch(I_ORI, 1, 4);
    add(I_ORI, 1, 1, S_T3, GRB | RO | YI,  0, 0, 0, 4);
    add(I_ORI, 1, 1, S_T4, CO | ZI,        1, 0, 0, 4);
    add(I_ORI, 1, 1, S_T5, ZLO | GRA | RI, 0, 0, 0, 4);
    // nop, then undefined opcode
    fetch(I_NOP, 1, 5);
    add(I_NOP, 1, 1, S_T3, NONE, 0, 0, 0, 5);
    fetch(I_ILL, 1, 6);
    add(I_ILL, 1, 1, S_T3, NONE, 0, 1, 0, 6);
    // ldi with run low throughout: completes, parks in IDLE, resumes
    fetch(I_LDI, 0, 7);
    add(I_LDI, 1, 0, S_T3, GRB | BAO | YI, 0, 0, 0, 7);
    add(I_LDI, 1, 0, S_T4, CO | ZI,        2, 0, 0, 7);
    add(I_LDI, 1, 0, S_T5, ZLO | GRA | RI, 0, 0, 0, 7);
    add(I_LDI, 1, 0, S_IDLE, NONE,         0, 0, 0, 8);
    add(I_HALT, 1, 1, S_IDLE, NONE,        0, 0, 0, 8);
    // halt: no retire, sticks in HALT
    fetch(I_HALT, 1, 8);
    add(I_HALT, 1, 1, S_T3,   NONE, 0, 0, 0, 8);
    add(I_HALT, 1, 1, S_HALT, NONE, 0, 0, 1, 8);
    add(I_HALT, 1, 1, S_HALT, NONE, 0, 0, 1, 8);
    seg1 = tbl.size();
    // addi up to T4 (reset is dropped there)
    fetch(I_ADDI, 1, 0);
    add(I_ADDI, 1, 1, S_T3, GRB | RO | YI, 0, 0, 0, 0);
    add(I_ADDI, 1, 1, S_T4, CO | ZI,       2, 0, 0, 0);
    seg2 = tbl.size();
    // full addi after restart, then next fetch shows the retire
    fetch(I_ADDI, 1, 0);
    add(I_ADDI, 1, 1, S_T3, GRB | RO | YI,  0, 0, 0, 0);
    add(I_ADDI, 1, 1, S_T4, CO | ZI,        2, 0, 0, 0);
    add(I_ADDI, 1, 1, S_T5, ZLO | GRA | RI, 0, 0, 0, 0);
    add(I_ADDI, 1, 1, S_T0, PCO | MARI | INCPC | ZI, 2, 0, 0, 1);

    reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = I_LDI;
    reset_n2 = 1'b0; run2 = 1'b0; mr2 = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    drive_range(0, seg1);

    // reset out of HALT clears halted and retired immediately
    reset_n = 1'b0; #1;
    check_reset("halt_reset");
    #1 reset_n = 1'b1; run = 1'b1; ir = I_ADDI;
    drive_range(seg1, seg2);

    // asynchronous reset in T4 of addi
    reset_n = 1'b0; #1;
    check_reset("t4_reset");
    #1 reset_n = 1'b1;
    drive_range(seg2, tbl.size());

    // timeout instance: memory never ready in T1
    @(negedge clk); reset_n2 = 1'b1; run2 = 1'b1; mr2 = 1'b0;
    @(posedge clk); @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("to_state_c%0d", i), 64'(st2), 64'(S_T1));
      check($sformatf("to_read_c%0d", i), 64'({c2[11], c2[12], flt2}),
            64'({1'b1, (i == 0), 1'b0}));
    end
    @(negedge clk);
    check("to_halt_state", 64'(st2), 64'(S_HALT));
    check("to_fault", 64'({flt2, hlt2, c2[11]}), 64'(3'b110));
    // ready arriving in the timeout cycle completes the fetch read
    #2 reset_n2 = 1'b0; #1;
    check("to_reset_fault", 64'({flt2, hlt2, st2}), 64'd0);
    #1 reset_n2 = 1'b1;
    @(posedge clk); @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) mr2 = 1'b1;
    end
    @(negedge clk);
    check("to_late_ready_state", 64'(st2), 64'(S_T2));
    check("to_late_ready_fault", 64'({flt2, hlt2}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
